// File: rtl/register_writer_pkg.sv
// Shared CPU definitions: write-back select codes and writer FSM states.
// The read selector imports the same select codes.
package cpu_defs;

  localparam logic [3:0] SEL_EBP  = 4'h1;
  localparam logic [3:0] SEL_ESP  = 4'h2;
  localparam logic [3:0] SEL_NONE = 4'h3;
  localparam logic [3:0] SEL_PUSH = 4'h4;
  localparam logic [3:0] SEL_POP  = 4'h5;
  localparam logic [3:0] SEL_EIP  = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_DEC = 3'd1,
    ST_PUSH_WR  = 3'd2,
    ST_POP_RD   = 3'd3,
    ST_POP_INC  = 3'd4
  } wr_state_t;

endpackage

// File: rtl/register_writer_if.sv
// Valid/ready write-back request channel from execute to register writer.
interface register_writer_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_sel;
  logic [31:0] wb_data;

  modport master (
    output wb_valid, wb_sel, wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_sel, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/register_writer_stack_ram.sv
// Stack word memory: synchronous write, asynchronous read, no reset.
module stack_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/register_writer.sv
// Architectural eip/ebp/esp owner and stack engine for write-back,
// push and pop requests from the execute stage.
module register_writer
  import cpu_defs::*;
#(
  parameter int          STACK_DEPTH = 16,
  parameter logic [31:0] ESP_RESET   = 32'(STACK_DEPTH * 4),
  parameter logic [31:0] EIP_RESET   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  register_writer_if.slave wb,
  input  logic        eip_step,
  output logic [31:0] eip,
  output logic [31:0] ebp,
  output logic [31:0] esp,
  output logic [31:0] stack,
  output logic        pop_valid,
  output logic [31:0] pop_data,
  output logic        stack_err
);

  localparam int          AW  = $clog2(STACK_DEPTH);
  localparam logic [31:0] TOP = 32'(STACK_DEPTH * 4);

  wr_state_t   state, nxt;
  logic [31:0] push_data;
  logic [31:0] rd_data;
  logic        ram_we;
  logic        accept;
  logic        is_push, is_pop;
  logic        push_err, pop_err;

  assign accept   = wb.wb_valid && wb.wb_ready;
  assign is_push  = accept && (wb.wb_sel == SEL_PUSH);
  assign is_pop   = accept && (wb.wb_sel == SEL_POP);
  assign push_err = is_push && (esp == 32'd0);
  assign pop_err  = is_pop && (esp >= TOP);

  stack_ram #(.DEPTH(STACK_DEPTH), .AW(AW)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (esp[AW+1:2]),
    .wdata (push_data),
    .raddr (esp[AW+1:2]),
    .rdata (rd_data)
  );

  assign stack = (esp < TOP) ? rd_data : 32'd0;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (is_push && !push_err)    nxt = ST_PUSH_DEC;
        else if (is_pop && !pop_err) nxt = ST_POP_RD;
      end
      ST_PUSH_DEC: nxt = ST_PUSH_WR;
      ST_PUSH_WR:  nxt = ST_IDLE;
      ST_POP_RD:   nxt = ST_POP_INC;
      ST_POP_INC:  nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  // Gating the write with reset_n makes a reset on the write edge abort it.
  always_comb begin
    wb.wb_ready = (state == ST_IDLE);
    ram_we      = (state == ST_PUSH_WR) && reset_n;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ebp       <= 32'd0;
      esp       <= ESP_RESET;
      push_data <= 32'd0;
      pop_data  <= 32'd0;
      pop_valid <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      pop_valid <= (state == ST_POP_INC);
      stack_err <= stack_err | push_err | pop_err;
      if (accept) begin
        case (wb.wb_sel)
          SEL_EBP:  ebp <= wb.wb_data;
          SEL_ESP:  esp <= {wb.wb_data[31:2], 2'b00};
          SEL_PUSH: push_data <= wb.wb_data;
          default:  ;
        endcase
      end
      unique case (1'b1)
        state == ST_PUSH_DEC: esp <= esp - 32'd4;
        state == ST_POP_RD:   pop_data <= rd_data;
        state == ST_POP_INC:  esp <= esp + 32'd4;
        default:              ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      eip <= EIP_RESET;
    else if (accept && wb.wb_sel == SEL_EIP)
      eip <= wb.wb_data;
    else if (eip_step)
      eip <= eip + 32'd4;
  end

endmodule

// File: tb/tb_register_writer.sv
// Directed self-checking bench for register_writer.
module tb_register_writer;
  import cpu_defs::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        eip_step;
  logic [31:0] eip, ebp, esp, stack, pop_data;
  logic        pop_valid, stack_err;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pv_cnt;

  register_writer_if wb();

  register_writer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wb        (wb),
    .eip_step  (eip_step),
    .eip       (eip),
    .ebp       (ebp),
    .esp       (esp),
    .stack     (stack),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .stack_err (stack_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] sel, input logic [31:0] data);
    wb.wb_valid = 1'b1;
    wb.wb_sel   = sel;
    wb.wb_data  = data;
    tick();
    wb.wb_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] data);
    req(SEL_PUSH, data);
    chk("push_busy1", 32'(wb.wb_ready), 32'd0);
    tick();
    chk("push_busy2", 32'(wb.wb_ready), 32'd0);
    tick();
    chk("push_done", 32'(wb.wb_ready), 32'd1);
  endtask

  task automatic pop(input logic [31:0] exp_data, input int exp_pulses);
    req(SEL_POP, 32'hDEAD_BEEF);
    pv_cnt = int'(pop_valid);
    repeat (3) begin
      tick();
      pv_cnt += int'(pop_valid);
    end
    chk("pop_pulses", 32'(pv_cnt), 32'(exp_pulses));
    chk("pop_data", pop_data, exp_data);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    wb.wb_valid = 1'b0;
    wb.wb_sel   = 4'h0;
    wb.wb_data  = 32'd0;
    eip_step    = 1'b0;
    do_reset();
    tick();
    chk("rst_esp", esp, 32'h40);
    chk("rst_eip", eip, 32'h0);
    chk("rst_ebp", ebp, 32'h0);
    chk("rst_ready", 32'(wb.wb_ready), 32'd1);
    chk("rst_err", 32'(stack_err), 32'd0);
    chk("rst_pv", 32'(pop_valid), 32'd0);
    chk("rst_stack", stack, 32'd0);

    eip_step = 1'b1;
    repeat (3) tick();
    eip_step = 1'b0;
    chk("eip_step3", eip, 32'hC);

    req(SEL_EBP, 32'h1234);
    chk("wr_ebp", ebp, 32'h1234);
    req(SEL_ESP, 32'h23);
    chk("wr_esp", esp, 32'h20);
    req(SEL_NONE, 32'h5555);
    chk("none_ebp", ebp, 32'h1234);
    chk("none_ready", 32'(wb.wb_ready), 32'd1);
    req(SEL_ESP, 32'h40);

    push(32'hAAAA0001);
    chk("push1_esp", esp, 32'h3C);
    chk("push1_stack", stack, 32'hAAAA0001);
    push(32'hBBBB0002);
    chk("push2_esp", esp, 32'h38);
    chk("push2_stack", stack, 32'hBBBB0002);

    pop(32'hBBBB0002, 1);
    chk("pop1_esp", esp, 32'h3C);
    pop(32'hAAAA0001, 1);
    chk("pop2_esp", esp, 32'h40);

    pop(32'hAAAA0001, 0);
    chk("under_err", 32'(stack_err), 32'd1);
    chk("under_esp", esp, 32'h40);

    req(SEL_EIP, 32'hFFFF_FFFC);
    eip_step = 1'b1;
    tick();
    chk("eip_wrap", eip, 32'h0);
    wb.wb_valid = 1'b1;
    wb.wb_sel   = SEL_EIP;
    wb.wb_data  = 32'h100;
    tick();
    wb.wb_valid = 1'b0;
    eip_step    = 1'b0;
    chk("eip_wr_wins", eip, 32'h100);

    req(SEL_PUSH, 32'hDEAD0000);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_esp", esp, 32'h40);
    chk("midrst_err", 32'(stack_err), 32'd0);
    chk("midrst_ready", 32'(wb.wb_ready), 32'd1);
    chk("midrst_eip", eip, 32'h0);
    req(SEL_ESP, 32'h3C);
    chk("midrst_mem", stack, 32'hAAAA0001);
    req(SEL_ESP, 32'h40);

    for (int i = 0; i < 16; i++) push(32'h1000 + 32'(i));
    chk("full_esp", esp, 32'h0);
    chk("full_stack", stack, 32'h100F);
    chk("full_err", 32'(stack_err), 32'd0);
    req(SEL_PUSH, 32'hFFFF_FFFF);
    chk("over_ready", 32'(wb.wb_ready), 32'd1);
    tick();
    tick();
    chk("over_err", 32'(stack_err), 32'd1);
    chk("over_esp", esp, 32'h0);
    chk("over_mem", stack, 32'h100F);
    req(SEL_ESP, 32'h3C);
    chk("bottom_mem", stack, 32'h1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_writer.md
Name: register_writer

Overview:
- Write-side counterpart of the register read selector.
- Owns the architectural eip, ebp and esp registers and a small word-addressed stack memory.
- Executes write-back, push and pop requests from the execute stage through a valid/ready handshake.
- Continuously presents eip, ebp, esp and the top-of-stack word to the read selector.

Parameters:
- STACK_DEPTH, 16: stack size in 32-bit words; must be a power of 2, minimum 4.
- ESP_RESET, STACK_DEPTH*4: esp value after reset (empty stack).
- EIP_RESET, 32'h0000_0000: eip value after reset.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- wb_valid  input  1  request valid.
- wb_ready  output  1  request accepted when wb_valid && wb_ready at a rising edge.
- wb_sel  input  4  destination/operation code (see Behaviour).
- wb_data  input  32  write data.
- eip_step  input  1  eip += 4 this cycle.
- eip  output  32  current instruction pointer.
- ebp  output  32  current base pointer.
- esp  output  32  current stack pointer.
- stack  output  32  mem[esp>>2] when esp < STACK_DEPTH*4, else 0.
- pop_valid  output  1  one-cycle pulse; pop_data is valid.
- pop_data  output  32  popped word, held until the next pop.
- stack_err  output  1  sticky overflow/underflow flag; cleared only by reset.

Behaviour:
- Reset (reset_n low at an edge):
  - eip=EIP_RESET, ebp=0, esp=ESP_RESET.
  - pop_valid=0, pop_data=0, stack_err=0, state=IDLE, wb_ready=1.
  - Stack memory contents are not reset.
  - Reset mid-operation aborts the operation with no memory write.
- wb_sel codes (match the read selector's encoding):
  - 4'h1 write ebp.
  - 4'h2 write esp. Bits [1:0] are forced to 0.
  - 4'h3 no destination (immediate path). Accepted and completes in one cycle with no state change.
  - 4'h4 push.
  - 4'h5 pop. wb_data is ignored.
  - 4'h6 write eip.
  - Any other code: accepted as a no-op.
- wb_ready is 1 only in IDLE.
- Single-cycle ops (1, 2, 3, 6, other): register updated on the accepting edge; state remains IDLE.
- Push: IDLE -> PUSH_DEC -> PUSH_WR -> IDLE.
  - Accepting edge latches wb_data.
  - PUSH_DEC edge: esp -= 4.
  - PUSH_WR edge: mem[esp>>2] = latched data.
  - Total 3 edges from acceptance to the next possible acceptance.
  - If esp == 0 at acceptance: set stack_err, return to IDLE; no esp change, no write.
- Pop: IDLE -> POP_RD -> POP_INC -> IDLE.
  - POP_RD edge: pop_data = mem[esp>>2].
  - POP_INC edge: esp += 4 and pop_valid = 1 for exactly one cycle.
  - If esp >= STACK_DEPTH*4 at acceptance: set stack_err, return to IDLE; no change, no pop_valid.
- eip_step:
  - Applies in any state.
  - If the same edge accepts a wb_sel 4'h6 write, the write wins and the step is dropped.
  - eip wraps modulo 2^32.
- Arithmetic: 32-bit unsigned. Stack index uses esp[log2(STACK_DEPTH)+1:2].
- stack output is combinational from esp and memory. After PUSH_WR it shows the pushed word one edge later.
- wb_valid while wb_ready=0: no effect. The requester holds the request.

Decomposition:
- Shared package (cpu_defs):
  - wb_sel code constants SEL_EBP=4'h1, SEL_ESP=4'h2, SEL_NONE=4'h3, SEL_PUSH=4'h4, SEL_POP=4'h5, SEL_EIP=4'h6. The read selector reuses these.
  - State encoding constants.
- One sub-module, stack_ram: synchronous-write, asynchronous-read STACK_DEPTH x 32 memory.
- FSM and pointer registers stay in register_writer.

Test Plan:
- Reset, then idle:
  - esp=0x40, eip=0, ebp=0, wb_ready=1, stack_err=0.
  - Three eip_step pulses -> eip=0xC.
- Write ebp (sel 1, 0x1234) -> ebp=0x1234 the next cycle.
- Write esp (sel 2, 0x23) -> esp=0x20.
- Push 0xAAAA0001 then 0xBBBB0002 from esp=0x40:
  - esp=0x38, stack=0xBBBB0002.
  - wb_ready low for 2 cycles after each acceptance.
- Two pops after those pushes:
  - pop_data=0xBBBB0002 then 0xAAAA0001, each with a single pop_valid pulse.
  - esp=0x40.
- Underflow/overflow:
  - Pop at esp=0x40 -> stack_err=1, esp unchanged, no pop_valid.
  - 16 pushes then a 17th -> stack_err=1, esp=0, mem[0] keeps the 16th value.
- Corner cases:
  - Same-edge eip write (sel 6, 0x100) and eip_step -> eip=0x100.
  - reset_n low during PUSH_DEC -> esp=0x40, no memory write.
